// File: rtl/i2c_target.sv
// I2C target responder: answers a 7-bit address and exposes an auto-incrementing
// 8-bit register bank to the bus, with a local host read/write port onto the same bank.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  input  logic                     host_wen,
  output logic [7:0]               host_rdata,
  output logic                     busy,
  output logic                     wr_pulse,
  output logic [$clog2(DEPTH)-1:0] wr_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  state_t          state, state_d;
  logic [2:0]      scl_q, sda_q;
  logic [CW-1:0]   cnt, cnt_d;
  logic [7:0]      sh, sh_d;
  logic [AW-1:0]   ptr, ptr_d;
  logic [AW-1:0]   wr_idx_d;
  logic            rw, rw_d;
  logic            oe_d, busy_d, wr_pulse_d;
  logic            i2c_we;
  logic [7:0]      regs [DEPTH];

  logic            scl_rise, scl_fall, start, stop, last_bit, addr_hit;
  logic [7:0]      byte_in, rd_byte;

  // [0] first sync flop, [1] synchronized value, [2] history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_comb begin
    scl_rise = scl_q[1] & ~scl_q[2];
    scl_fall = ~scl_q[1] & scl_q[2];
    start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    byte_in  = {sh[6:0], sda_q[1]};
    last_bit = (cnt == CW'(7));
    addr_hit = (byte_in[7:1] == TARGET_ADDR);
    rd_byte  = regs[ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state: STOP and START override every state, including mid-byte
  always_comb begin
    state_d = state;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_rise && last_bit) state_d = addr_hit ? ADDR_ACK : WAIT;
        ADDR_ACK:  if (scl_fall && sda_oe)   state_d = rw ? RDATA : PTR;
        PTR:       if (scl_rise && last_bit) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall && sda_oe)   state_d = WDATA;
        WDATA:     if (scl_rise && last_bit) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && sda_oe)   state_d = WDATA;
        RDATA:     if (scl_fall && cnt == CW'(8)) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_q[1]) state_d = WAIT;
          else if (scl_fall)        state_d = RDATA;
        end
        default:   state_d = state;
      endcase
    end
  end

  // Datapath/output next values; SDA only ever changes on a detected SCL fall
  always_comb begin
    cnt_d      = cnt;
    sh_d       = sh;
    ptr_d      = ptr;
    rw_d       = rw;
    oe_d       = sda_oe;
    busy_d     = busy;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx;
    i2c_we     = 1'b0;
    if (stop) begin
      oe_d   = 1'b0;
      busy_d = 1'b0;
    end else if (start) begin
      cnt_d = '0;
      oe_d  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt + CW'(1);
            if (last_bit) begin
              if (state == ADDR) begin
                rw_d   = byte_in[0];
                busy_d = addr_hit;
              end else if (state == PTR) begin
                ptr_d = byte_in[AW-1:0];
              end else begin
                i2c_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_idx_d   = ptr;
                ptr_d      = ptr + AW'(1);
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            oe_d  = ~sda_oe;
            cnt_d = '0;
            if (sda_oe && state == ADDR_ACK && rw) begin
              oe_d  = ~rd_byte[7];
              sh_d  = {rd_byte[6:0], 1'b0};
              cnt_d = CW'(1);
              ptr_d = ptr + AW'(1);
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt == CW'(8)) begin
              oe_d = 1'b0;
            end else begin
              oe_d  = ~sh[7];
              sh_d  = {sh[6:0], 1'b0};
              cnt_d = cnt + CW'(1);
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && sda_q[1]) begin
            busy_d = 1'b0;
          end else if (scl_fall) begin
            oe_d  = ~rd_byte[7];
            sh_d  = {rd_byte[6:0], 1'b0};
            cnt_d = CW'(1);
            ptr_d = ptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sh       <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      cnt      <= cnt_d;
      sh       <= sh_d;
      ptr      <= ptr_d;
      rw       <= rw_d;
      sda_oe   <= oe_d;
      busy     <= busy_d;
      wr_pulse <= wr_pulse_d;
      wr_idx   <= wr_idx_d;
    end
  end

  // Register bank: I2C write wins a same-index collision; read port bypasses same-cycle writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      host_rdata <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i2c_we && ptr == AW'(i))              regs[i] <= byte_in;
        else if (host_wen && host_addr == AW'(i)) regs[i] <= host_wdata;
      end
      if (i2c_we && ptr == host_addr) host_rdata <= byte_in;
      else if (host_wen)              host_rdata <= host_wdata;
      else                            host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, host-port checks and a
// scoreboard of expected write-commit indices popped on each wr_pulse.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl_in;
  logic          sda_ctl;
  wire           sda_in;
  logic          sda_oe;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_wen;
  logic [7:0]    host_rdata;
  logic          busy;
  logic          wr_pulse;
  logic [AW-1:0] wr_idx;

  // Open-drain bus: either side can pull SDA low
  assign sda_in = sda_ctl & ~sda_oe;

  i2c_target #(.TARGET_ADDR(7'h42), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_wen(host_wen),
    .host_rdata(host_rdata), .busy(busy), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic oe_seen   = 1'b0;
  logic busy_seen = 1'b0;
  logic [AW-1:0] exp_wr [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-commit monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
      if (wr_pulse) begin
        wr_count++;
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_idx), 32'hFFFF_FFFF);
        else                    check("wr_idx", 32'(wr_idx), 32'(exp_wr.pop_front()));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_ctl = 1'b1; wait_n(5);
    scl_in  = 1'b1; wait_n(10);
    sda_ctl = 1'b0; wait_n(10);
    scl_in  = 1'b0; wait_n(5);
  endtask

  task automatic i2c_stop();
    sda_ctl = 1'b0; wait_n(5);
    scl_in  = 1'b1; wait_n(10);
    sda_ctl = 1'b1; wait_n(10);
  endtask

  task automatic send_bit(input logic b);
    sda_ctl = b;    wait_n(5);
    scl_in  = 1'b1; wait_n(10);
    scl_in  = 1'b0; wait_n(5);
  endtask

  task automatic recv_bit(output logic b);
    sda_ctl = 1'b1; wait_n(5);
    scl_in  = 1'b1; wait_n(5);
    b = sda_in;     wait_n(5);
    scl_in  = 1'b0; wait_n(5);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_wen = 1'b1;
    @(negedge clk);
    host_wen = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wen = 1'b0;
    @(negedge clk);
    d = host_rdata;
  endtask

  logic       ack;
  logic [7:0] rd;
  int         wr_base;

  initial begin
    rst = 1'b1; scl_in = 1'b1; sda_ctl = 1'b1;
    host_addr = '0; host_wdata = '0; host_wen = 1'b0;
    wait_n(3);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    check("rst_wr_idx", 32'(wr_idx), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);
    rst = 1'b0;
    wait_n(2);
    host_read(4'd9, rd); check("rst_reg9", 32'(rd), 0);

    // Write burst
    i2c_start();
    send_byte(8'h84, ack); check("wb_addr_ack", 32'(ack), 0);
    check("wb_busy", 32'(busy), 1);
    send_byte(8'h03, ack); check("wb_ptr_ack", 32'(ack), 0);
    exp_wr.push_back(4'd3);
    send_byte(8'hA5, ack); check("wb_d0_ack", 32'(ack), 0);
    exp_wr.push_back(4'd4);
    send_byte(8'h5A, ack); check("wb_d1_ack", 32'(ack), 0);
    i2c_stop();
    check("wb_busy_after_stop", 32'(busy), 0);
    check("wb_pulses", 32'(wr_count), 2);
    host_read(4'd3, rd); check("wb_reg3", 32'(rd), 32'hA5);
    host_read(4'd4, rd); check("wb_reg4", 32'(rd), 32'h5A);

    // Read with pointer wrap
    host_write(4'd15, 8'h11);
    host_write(4'd0, 8'h22);
    i2c_start();
    send_byte(8'h84, ack); check("rd_waddr_ack", 32'(ack), 0);
    send_byte(8'h0F, ack); check("rd_ptr_ack", 32'(ack), 0);
    i2c_start();
    send_byte(8'h85, ack); check("rd_raddr_ack", 32'(ack), 0);
    recv_byte(rd, 1'b0); check("rd_byte0", 32'(rd), 32'h11);
    check("rd_busy_mid", 32'(busy), 1);
    recv_byte(rd, 1'b1); check("rd_byte1", 32'(rd), 32'h22);
    wait_n(3);
    check("rd_busy_after_nack", 32'(busy), 0);
    check("rd_oe_after_nack", 32'(sda_oe), 0);
    i2c_stop();

    // Address mismatch
    wr_base = wr_count;
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    send_byte(8'h90, ack); check("mm_addr_nack", 32'(ack), 1);
    send_byte(8'hFF, ack); check("mm_data_nack", 32'(ack), 1);
    i2c_stop();
    check("mm_oe_never", 32'(oe_seen), 0);
    check("mm_busy_never", 32'(busy_seen), 0);
    check("mm_no_pulse", 32'(wr_count - wr_base), 0);

    // Host/I2C collision on reg[2]: host strobe lands on the commit edge
    i2c_start();
    send_byte(8'h84, ack); check("co_addr_ack", 32'(ack), 0);
    send_byte(8'h02, ack); check("co_ptr_ack", 32'(ack), 0);
    exp_wr.push_back(4'd2);
    rd = 8'hC3;
    for (int i = 7; i >= 1; i--) send_bit(rd[i]);
    sda_ctl = rd[0]; wait_n(5);
    scl_in = 1'b1;   wait_n(2);
    host_addr = 4'd2; host_wdata = 8'h33; host_wen = 1'b1;
    wait_n(1);
    host_wen = 1'b0;
    check("co_rdata_bypass", 32'(host_rdata), 32'hC3);
    wait_n(7);
    scl_in = 1'b0;   wait_n(5);
    recv_bit(ack); check("co_data_ack", 32'(ack), 0);
    i2c_stop();
    host_read(4'd2, rd); check("co_reg2", 32'(rd), 32'hC3);

    // Abort mid-byte with STOP, then a clean write
    i2c_start();
    send_byte(8'h84, ack); check("ab_addr_ack", 32'(ack), 0);
    send_byte(8'h07, ack); check("ab_ptr_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    wait_n(3);
    check("ab_oe", 32'(sda_oe), 0);
    check("ab_busy", 32'(busy), 0);
    host_read(4'd7, rd); check("ab_reg7_kept", 32'(rd), 0);
    i2c_start();
    send_byte(8'h84, ack); check("ab2_addr_ack", 32'(ack), 0);
    send_byte(8'h07, ack); check("ab2_ptr_ack", 32'(ack), 0);
    exp_wr.push_back(4'd7);
    send_byte(8'h96, ack); check("ab2_data_ack", 32'(ack), 0);
    i2c_stop();
    host_read(4'd7, rd); check("ab2_reg7", 32'(rd), 32'h96);

    // Reset while the target drives ACK
    i2c_start();
    send_byte(8'h84, ack); check("rr_addr_ack", 32'(ack), 0);
    for (int i = 7; i >= 0; i--) send_bit(i == 0);
    sda_ctl = 1'b1; wait_n(5);
    scl_in  = 1'b1; wait_n(5);
    check("rr_oe_before", 32'(sda_oe), 1);
    rst = 1'b1;
    wait_n(1);
    check("rr_oe_after", 32'(sda_oe), 0);
    check("rr_busy_after", 32'(busy), 0);
    wait_n(2);
    rst = 1'b0;
    wait_n(2);
    host_read(4'd3, rd);  check("rr_reg3", 32'(rd), 0);
    host_read(4'd2, rd);  check("rr_reg2", 32'(rd), 0);
    host_read(4'd7, rd);  check("rr_reg7", 32'(rd), 0);
    host_read(4'd15, rd); check("rr_reg15", 32'(rd), 0);

    check("wr_queue_drained", 32'(exp_wr.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
